// File: rtl/pad_io_pkg.sv
// Shared types and defaults for the pad I/O sequencer: FSM states,
// transfer direction and counter-width helper.
package pad_io_pkg;

    localparam int PIO_WIDTH_DEF      = 8;
    localparam int PIO_BIT_CYCLES_DEF = 4;
    localparam int PIO_TA_CYCLES_DEF  = 2;

    typedef enum logic [2:0] {
        PIO_IDLE,
        PIO_TA_PRE,
        PIO_TX,
        PIO_RX,
        PIO_TA_POST
    } pio_state_t;

    typedef enum logic {
        PIO_DIR_TX = 1'b0,
        PIO_DIR_RX = 1'b1
    } pio_dir_t;

    // Counter width for a modulo-n counter, never narrower than one bit.
    function automatic int pio_cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pad_io_bit_timer.sv
// Free-running BIT_CYCLES-period counter; bit_end_o marks the last cycle
// of each serial bit and clr_i restarts the period.
module pad_io_bit_timer
    import pad_io_pkg::*;
#(
    parameter int BIT_CYCLES = PIO_BIT_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    output logic bit_end_o
);

    localparam int            CW   = pio_cw(BIT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign bit_end_o = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr_i || bit_end_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pad_io_sequencer.sv
// Half-duplex sequencer sharing one bidirectional pad between a TX and an
// RX requester, with enforced all-off turnaround around every transfer.
module pad_io_sequencer
    import pad_io_pkg::*;
#(
    parameter int WIDTH      = PIO_WIDTH_DEF,
    parameter int BIT_CYCLES = PIO_BIT_CYCLES_DEF,
    parameter int TA_CYCLES  = PIO_TA_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             rx_req,
    output logic             rx_valid,
    output logic [WIDTH-1:0] rx_data,
    output logic             pad_ie,
    output logic             pad_oe,
    output logic             pad_in,
    input  logic             pad_out,
    output logic             busy
);

    localparam int             TCW      = pio_cw(TA_CYCLES);
    localparam int             BCW      = $clog2(WIDTH + 1);
    localparam logic [TCW-1:0] TA_LAST  = TCW'(TA_CYCLES - 1);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(WIDTH - 1);

    pio_state_t       state_q, state_d;
    pio_dir_t         dir_q, dir_d;
    pio_dir_t         last_grant_q, last_grant_d;
    logic [TCW-1:0]   ta_cnt_q, ta_cnt_d;
    logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             bit_end;
    logic             state_change;
    logic             grant_tx;
    logic             grant_rx;

    // Round-robin only matters when both requesters are pending.
    always_comb begin
        grant_tx = 1'b0;
        grant_rx = 1'b0;
        if (state_q == PIO_IDLE && !rst) begin
            if (tx_valid && rx_req) begin
                grant_tx = (last_grant_q == PIO_DIR_RX);
                grant_rx = (last_grant_q == PIO_DIR_TX);
            end else begin
                grant_tx = tx_valid;
                grant_rx = rx_req;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        dir_d        = dir_q;
        last_grant_d = last_grant_q;
        ta_cnt_d     = ta_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        case (state_q)
            PIO_IDLE: begin
                if (grant_tx) begin
                    state_d      = PIO_TA_PRE;
                    dir_d        = PIO_DIR_TX;
                    last_grant_d = PIO_DIR_TX;
                    shreg_d      = tx_data;
                end else if (grant_rx) begin
                    state_d      = PIO_TA_PRE;
                    dir_d        = PIO_DIR_RX;
                    last_grant_d = PIO_DIR_RX;
                    shreg_d      = '0;
                end
            end
            PIO_TA_PRE: begin
                ta_cnt_d = ta_cnt_q + 1'b1;
                if (ta_cnt_q == TA_LAST) begin
                    state_d = (dir_q == PIO_DIR_TX) ? PIO_TX : PIO_RX;
                end
            end
            PIO_TX, PIO_RX: begin
                if (bit_end) begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (state_q == PIO_TX) begin
                        shreg_d = shreg_q << 1;
                    end else begin
                        shreg_d = (shreg_q << 1) | WIDTH'(pad_out);
                    end
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = PIO_TA_POST;
                        if (state_q == PIO_RX) begin
                            rx_data_d  = shreg_d;
                            rx_valid_d = 1'b1;
                        end
                    end
                end
            end
            PIO_TA_POST: begin
                ta_cnt_d = ta_cnt_q + 1'b1;
                if (ta_cnt_q == TA_LAST) begin
                    state_d = PIO_IDLE;
                end
            end
            default: state_d = PIO_IDLE;
        endcase
        if (state_d != state_q) begin
            ta_cnt_d  = '0;
            bit_cnt_d = '0;
        end
    end

    assign state_change = (state_d != state_q);

    pad_io_bit_timer #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_bit_timer (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (state_change),
        .bit_end_o(bit_end)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= PIO_IDLE;
            dir_q        <= PIO_DIR_TX;
            last_grant_q <= PIO_DIR_RX;
            ta_cnt_q     <= '0;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            last_grant_q <= last_grant_d;
            ta_cnt_q     <= ta_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
        end
    end

    // Enables come straight from the state register, so both are low in
    // every turnaround cycle and can never overlap.
    assign tx_ready = grant_tx;
    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;
    assign busy     = (state_q != PIO_IDLE);
    assign pad_oe   = (state_q == PIO_TX);
    assign pad_ie   = (state_q == PIO_RX);
    assign pad_in   = pad_oe & shreg_q[WIDTH-1];

endmodule

// File: doc/pad_io_sequencer.md
# pad_io_sequencer

Half-duplex sequencer for one bidirectional `pad_cell`. It owns the cell's `ie`/`oe` enables and shares the single pad between a transmit requester and a receive requester. It serialises a parallel word onto the pad (MSB first) or captures a word from it. Every direction change passes through a turnaround window in which both enables are low, so the pad is never driven while being sampled.

## Interface
Parameters:
- `WIDTH`, 8: bits per transfer word (≥1).
- `BIT_CYCLES`, 4: clocks per serial bit (≥1).
- `TA_CYCLES`, 2: turnaround clocks with `ie=oe=0` before and after every transfer (≥1).

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `tx_valid`  in  1  transmit word available.
- `tx_ready`  out  1  sequencer accepts `tx_data` this cycle.
- `tx_data`  in  WIDTH  word to transmit.
- `rx_req`  in  1  level request for one receive transfer.
- `rx_valid`  out  1  one-cycle pulse: `rx_data` updated.
- `rx_data`  out  WIDTH  last received word, held until the next `rx_valid`.
- `pad_ie`  out  1  to `pad_cell.ie`.
- `pad_oe`  out  1  to `pad_cell.oe`.
- `pad_in`  out  1  to `pad_cell.in`; the bit driven onto the pad.
- `pad_out`  in  1  from `pad_cell.out`; the bit sampled from the pad.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States:
  - IDLE
  - TA_PRE: turnaround before a transfer.
  - TX
  - RX
  - TA_POST: turnaround after a transfer.
- Arbitration:
  - Happens only in IDLE.
  - Candidates are `tx_valid` and `rx_req`.
  - When both are high, round-robin applies; a `last_grant` flag records the last winner.
  - After reset, TX has priority.
- TX grant:
  - `tx_ready=1` for that IDLE cycle.
  - The handshake `tx_valid&tx_ready` loads the shift register with `tx_data`.
  - Next state is TA_PRE with direction = TX.
- RX grant:
  - Next state is TA_PRE with direction = RX.
  - `rx_req` is not sampled again until the following IDLE.
- TA_PRE: `ie=oe=0` for TA_CYCLES, then go to TX or RX.
- TX:
  - `oe=1`, `ie=0`.
  - `pad_in` is the shift-register MSB.
  - The register shifts left at the end of each BIT_CYCLES period.
  - After WIDTH bits, go to TA_POST.
- RX:
  - `ie=1`, `oe=0`.
  - `pad_out` is sampled on the last cycle of each bit period and shifted in at the LSB, MSB arriving first.
  - After WIDTH bits, go to TA_POST.
- TA_POST:
  - `ie=oe=0` for TA_CYCLES, then IDLE.
  - For RX transfers, the first TA_POST cycle loads `rx_data` and pulses `rx_valid`.
- Invariant: `pad_ie & pad_oe` is never 1.
- `pad_in` is 0 whenever `pad_oe=0`.
- Counters:
  - Bit-cycle counter is `$clog2(BIT_CYCLES)` wide (min 1); turnaround counter is `$clog2(TA_CYCLES)` wide (min 1).
  - Bit counter is `$clog2(WIDTH+1)` wide.
  - All counters clear on every state entry.

## Timing
- Reset values:
  - State IDLE.
  - `pad_ie`, `pad_oe`, `pad_in`, `tx_ready`, `rx_valid`, `busy` all = 0.
  - `rx_data` = 0; `last_grant` selects RX, so TX wins first.
- `tx_ready` is combinational from state, `last_grant`, `tx_valid` and `rx_req`.
- `pad_ie`, `pad_oe` and `pad_in` are registered, i.e. decoded from the state register.
- Grant in cycle N gives this schedule:
  - TA_PRE: N+1 … N+TA_CYCLES.
  - Data: N+TA_CYCLES+1 … N+TA_CYCLES+WIDTH·BIT_CYCLES.
  - TA_POST: the next TA_CYCLES cycles.
  - IDLE: cycle N+2·TA_CYCLES+WIDTH·BIT_CYCLES+1, earliest next grant.
- `rx_valid` fires in cycle N+TA_CYCLES+WIDTH·BIT_CYCLES+1.
- Reset mid-transfer:
  - The next cycle is IDLE with all enables 0.
  - The transfer is dropped; no `rx_valid`, and `rx_data` is reset to 0.
- A `tx_valid` drop while in TX does not affect the transfer in flight.

## Structure
- `pad_io_pkg` holds:
  - the state enum (`PIO_IDLE`, `PIO_TA_PRE`, `PIO_TX`, `PIO_RX`, `PIO_TA_POST`);
  - the direction enum;
  - default parameter constants.
- Sub-module `pad_io_bit_timer`: a BIT_CYCLES-period counter emitting `bit_end`, with a synchronous clear. It is instantiated once.

## Test plan
All scenarios use WIDTH=8, BIT_CYCLES=4, TA_CYCLES=2, with a real `pad_cell` instance and a tri-state bench driver.
- Reset: hold `rst` 3 cycles with random inputs → all outputs 0, `busy=0`, pad is Z.
- TX 0xA5: grant at N → `ie=oe=0` at N+1..N+2; `oe=1` at N+3..N+34 with pad = 1,0,1,0,0,1,0,1, each held 4 cycles; enables 0 at N+35..N+36; `tx_ready` available at N+37.
- RX 0x3C: bench drives the pattern only while `ie=1` → `rx_valid` single pulse at N+35, `rx_data=0x3C`, no pad contention.
- Contention: `tx_valid` and `rx_req` held high from reset → grants go TX, RX, TX, RX; never back-to-back without the 2+2 turnaround.
- Reset mid-TX at 10th drive cycle → next cycle `oe=0`, IDLE, no `rx_valid`; a fresh 0xFF transmits correctly afterwards.
- Invariant: concurrent assertion that `pad_ie & pad_oe` is never 1 and no X appears on the pad across all scenarios.
